// File: rtl/xadc_drp_config_writer_if.sv
// DRP bus bundle: the application-side read port and the XADC-side DRP port.
// The writer takes the master modport. The XADC/application side takes the slave modport.
interface xadc_drp_config_writer_if;
  logic        app_den;
  logic [6:0]  app_daddr;
  logic        app_drdy;
  logic [15:0] app_do;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (
    input  app_den, app_daddr, drp_do, drp_drdy,
    output app_drdy, app_do, drp_den, drp_dwe, drp_daddr, drp_di
  );

  modport slave (
    output app_den, app_daddr, drp_do, drp_drdy,
    input  app_drdy, app_do, drp_den, drp_dwe, drp_daddr, drp_di
  );
endinterface

// File: rtl/xadc_drp_config_writer.sv
// XADC configuration writer. It programs the config registers over DRP after reset
// or on request, optionally reads each one back and retries on a mismatch, and
// passes application reads straight through whenever it is not using the bus.
//
// state     | meaning
// S_IDLE    | pass-through, no sequence run yet
// S_WR_REQ  | one-cycle DRP write of table[idx]
// S_WR_WAIT | waiting for write drdy (timed)
// S_RD_REQ  | one-cycle DRP read-back of table[idx]
// S_RD_WAIT | waiting for read drdy (timed), compare data
// S_NEXT    | advance to next table entry or finish
// S_DONE    | pass-through, sequence succeeded
// S_ERROR   | pass-through, sequence failed at err_addr
module xadc_drp_config_writer #(
  parameter logic [15:0] CFG0_VAL       = 16'h3000,
  parameter logic [15:0] CFG1_VAL       = 16'h2000,
  parameter logic [15:0] CFG2_VAL       = 16'h0400,
  parameter logic [15:0] SEQ_AUX_VAL    = 16'h8000,
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  xadc_drp_config_writer_if.master     bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [6:0]                   err_addr
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [2:0]    retry, retry_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic [6:0]    err_q, err_nxt;
  logic          app_pending, start_req, auto_req;
  logic          pass, accept;
  logic [6:0]    ent_addr;
  logic [15:0]   ent_data;

  // Fixed programming table; the sequencer is parked first so the other regs land safely.
  always_comb begin
    ent_addr = 7'h41;
    ent_data = CFG1_VAL & 16'h0FFF;
    case (idx)
      3'd1: begin ent_addr = 7'h40; ent_data = CFG0_VAL;    end
      3'd2: begin ent_addr = 7'h42; ent_data = CFG2_VAL;    end
      3'd3: begin ent_addr = 7'h4B; ent_data = SEQ_AUX_VAL; end
      3'd4: begin ent_addr = 7'h41; ent_data = CFG1_VAL;    end
      default: ;
    endcase
  end

  // A start is held off while an app read is outstanding; it may go on the cycle that read's drdy arrives.
  always_comb begin
    pass   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    accept = pass && (start || start_req || auto_req) && !bus.app_den &&
             (!app_pending || bus.drp_drdy);
  end

  // Next-state, counters and DRP/app bus muxing.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    retry_nxt     = retry;
    tmo_nxt       = tmo;
    err_nxt       = err_q;
    bus.drp_den   = 1'b0;
    bus.drp_dwe   = 1'b0;
    bus.drp_daddr = ent_addr;
    bus.drp_di    = 16'h0000;
    bus.app_drdy  = 1'b0;
    bus.app_do    = 16'h0000;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        bus.drp_den   = bus.app_den;
        bus.drp_daddr = bus.app_daddr;
        bus.app_drdy  = bus.drp_drdy;
        bus.app_do    = bus.drp_do;
        if (accept) begin
          state_nxt = S_WR_REQ;
          idx_nxt   = 3'd0;
          retry_nxt = 3'd0;
          err_nxt   = 7'h00;
        end
      end
      S_WR_REQ: begin
        bus.drp_den = 1'b1;
        bus.drp_dwe = 1'b1;
        bus.drp_di  = ent_data;
        tmo_nxt     = '0;
        state_nxt   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus.drp_drdy) begin
          state_nxt = VERIFY ? S_RD_REQ : S_NEXT;
        end else if (tmo == TMO_LAST) begin
          state_nxt = S_ERROR;
          err_nxt   = ent_addr;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      S_RD_REQ: begin
        bus.drp_den = 1'b1;
        tmo_nxt     = '0;
        state_nxt   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.drp_drdy) begin
          if (bus.drp_do == ent_data) begin
            state_nxt = S_NEXT;
          end else if (retry < RETRY_MAX) begin
            retry_nxt = retry + 3'd1;
            state_nxt = S_WR_REQ;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = ent_addr;
          end
        end else if (tmo == TMO_LAST) begin
          state_nxt = S_ERROR;
          err_nxt   = ent_addr;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx == 3'd4) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 3'd1;
          retry_nxt = 3'd0;
          state_nxt = S_WR_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and start/app bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      retry       <= 3'd0;
      tmo         <= '0;
      err_q       <= 7'h00;
      app_pending <= 1'b0;
      start_req   <= 1'b0;
      auto_req    <= AUTO_START;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;
      tmo   <= tmo_nxt;
      err_q <= err_nxt;
      if (pass && bus.app_den)  app_pending <= 1'b1;
      else if (bus.drp_drdy)    app_pending <= 1'b0;
      if (accept)               start_req <= 1'b0;
      else if (pass && start)   start_req <= 1'b1;
      if (accept)               auto_req <= 1'b0;
    end
  end

  assign busy     = !pass;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign err_addr = err_q;

endmodule
